xc_malu_seq: RTL and testbench

Issue-side sequencer for the `xc_malu` multiply/divide unit. It accepts one arithmetic request at a time from the execute stage and drives the `xc_malu` valid/ready/flush interface, holding operands stable until the unit completes. Two-phase operations (multiply-subtract and multiply-accumulate) are split into their `_1`/`_2` micro-ops, with the intermediate result carried internally. The final 64-bit result is returned on a response valid/ready channel.

---
 rtl/xc_malu_pkg.sv | 44 ++++
 rtl/xc_malu_seq_dec.sv | 36 +++
 rtl/xc_malu_seq.sv | 163 ++++++++++++++++
 tb/tb_xc_malu_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xc_malu_pkg.sv
// Shared encodings and types for the xc_malu multiply/divide unit
// and its issue-side sequencer.
package xc_malu_pkg;

    localparam logic [3:0] OP_DIV  = 4'd0;
    localparam logic [3:0] OP_REM  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_MADD = 4'd3;
    localparam logic [3:0] OP_MSUB = 4'd4;
    localparam logic [3:0] OP_MACC = 4'd5;

    localparam logic [2:0] PW_32 = 3'd0;
    localparam logic [2:0] PW_16 = 3'd1;
    localparam logic [2:0] PW_8  = 3'd2;
    localparam logic [2:0] PW_4  = 3'd3;
    localparam logic [2:0] PW_2  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE1,
        S_ISSUE2,
        S_RESP
    } seq_state_t;

    typedef struct packed {
        logic div;
        logic rem;
        logic mul;
        logic madd;
        logic msub_1;
        logic msub_2;
        logic macc_1;
        logic macc_2;
    } uop_t;

    typedef struct packed {
        logic p32;
        logic p16;
        logic p8;
        logic p4;
        logic p2;
    } pw_t;

endpackage

// File: rtl/xc_malu_seq_dec.sv
// Decode of a request op/pw into first-phase one-hot micro-op and
// packed-width lines, plus the illegal-request flag.
module xc_malu_seq_dec
    import xc_malu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [2:0] pw,
    output uop_t       uop,
    output pw_t        pw_oh,
    output logic       illegal
);

    always_comb begin
        uop     = '0;
        pw_oh   = '0;
        illegal = (op > OP_MACC) || (pw > PW_2);
        unique case (op)
            OP_DIV:  uop.div    = 1'b1;
            OP_REM:  uop.rem    = 1'b1;
            OP_MUL:  uop.mul    = 1'b1;
            OP_MADD: uop.madd   = 1'b1;
            OP_MSUB: uop.msub_1 = 1'b1;
            OP_MACC: uop.macc_1 = 1'b1;
            default: ;
        endcase
        unique case (pw)
            PW_32:   pw_oh.p32 = 1'b1;
            PW_16:   pw_oh.p16 = 1'b1;
            PW_8:    pw_oh.p8  = 1'b1;
            PW_4:    pw_oh.p4  = 1'b1;
            PW_2:    pw_oh.p2  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/xc_malu_seq.sv
// Issue-side sequencer for xc_malu: one request in flight, two-phase
// ops split into _1/_2 micro-ops with the intermediate kept in acc.
module xc_malu_seq
    import xc_malu_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        abort,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic        req_lh_sign,
    input  logic        req_rh_sign,
    input  logic        req_carryless,
    input  logic [2:0]  req_pw,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [31:0] req_rs3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic        malu_valid,
    input  logic        malu_ready,
    output logic        malu_flush,
    output logic [31:0] malu_rs1,
    output logic [31:0] malu_rs2,
    output logic [31:0] malu_rs3,
    output logic        malu_uop_div,
    output logic        malu_uop_rem,
    output logic        malu_uop_mul,
    output logic        malu_uop_madd,
    output logic        malu_uop_msub_1,
    output logic        malu_uop_msub_2,
    output logic        malu_uop_macc_1,
    output logic        malu_uop_macc_2,
    output logic        malu_mod_lh_sign,
    output logic        malu_mod_rh_sign,
    output logic        malu_mod_carryless,
    output logic        malu_pw_32,
    output logic        malu_pw_16,
    output logic        malu_pw_8,
    output logic        malu_pw_4,
    output logic        malu_pw_2,
    input  logic [63:0] malu_result
);

    seq_state_t  state;
    uop_t        uop_q;
    pw_t         pw_q;
    logic        lh_q;
    logic        rh_q;
    logic        cl_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] rs3_q;
    logic [63:0] acc_q;
    logic [63:0] res_q;

    uop_t        dec_uop;
    pw_t         dec_pw;
    logic        dec_illegal;
    logic        two_phase;
    logic        in_issue2;

    xc_malu_seq_dec u_dec (
        .op      (req_op),
        .pw      (req_pw),
        .uop     (dec_uop),
        .pw_oh   (dec_pw),
        .illegal (dec_illegal)
    );

    assign two_phase = uop_q.msub_1 | uop_q.macc_1;
    assign in_issue2 = (state == S_ISSUE2);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
            uop_q <= '0;
            pw_q  <= '0;
            lh_q  <= 1'b0;
            rh_q  <= 1'b0;
            cl_q  <= 1'b0;
            rs1_q <= '0;
            rs2_q <= '0;
            rs3_q <= '0;
            acc_q <= '0;
            res_q <= '0;
        end else if (abort) begin
            // Any same-cycle xc_malu completion is dropped with the op.
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        uop_q <= dec_uop;
                        pw_q  <= dec_pw;
                        lh_q  <= req_lh_sign;
                        rh_q  <= req_rh_sign;
                        cl_q  <= req_carryless;
                        rs1_q <= req_rs1;
                        rs2_q <= req_rs2;
                        rs3_q <= req_rs3;
                        if (dec_illegal) begin
                            res_q <= '0;
                            state <= S_RESP;
                        end else begin
                            state <= S_ISSUE1;
                        end
                    end
                end
                S_ISSUE1: begin
                    if (malu_ready) begin
                        if (two_phase) begin
                            acc_q <= malu_result;
                            uop_q <= '{msub_2: uop_q.msub_1,
                                       macc_2: uop_q.macc_1,
                                       default: 1'b0};
                            state <= S_ISSUE2;
                        end else begin
                            res_q <= malu_result;
                            state <= S_RESP;
                        end
                    end
                end
                S_ISSUE2: begin
                    if (malu_ready) begin
                        res_q <= malu_result;
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Reset is synchronous, so outputs are gated to read 0 during it.
    assign req_ready  = resetn && !abort && (state == S_IDLE);
    assign rsp_valid  = resetn && (state == S_RESP);
    assign rsp_result = resetn ? res_q : '0;
    assign malu_valid = resetn &&
                        ((state == S_ISSUE1) || (state == S_ISSUE2));
    assign malu_flush = malu_valid && (malu_ready || abort);

    assign malu_rs1 = !resetn ? '0 : (in_issue2 ? acc_q[31:0] : rs1_q);
    assign malu_rs2 = !resetn ? '0 : (in_issue2 ? acc_q[63:32] : rs2_q);
    assign malu_rs3 = resetn ? rs3_q : '0;

    assign {malu_uop_div, malu_uop_rem, malu_uop_mul, malu_uop_madd,
            malu_uop_msub_1, malu_uop_msub_2,
            malu_uop_macc_1, malu_uop_macc_2} = resetn ? uop_q : '0;

    assign malu_mod_lh_sign   = resetn && lh_q;
    assign malu_mod_rh_sign   = resetn && rh_q;
    assign malu_mod_carryless = resetn && cl_q;

    assign {malu_pw_32, malu_pw_16, malu_pw_8,
            malu_pw_4, malu_pw_2} = resetn ? pw_q : '0;

endmodule

// File: tb/tb_xc_malu_seq.sv
// Directed bench for xc_malu_seq; xc_malu side is driven by hand
// with precomputed results.
module tb_xc_malu_seq;

    logic        clock = 1'b0;
    logic        resetn;
    logic        abort;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic        req_lh_sign;
    logic        req_rh_sign;
    logic        req_carryless;
    logic [2:0]  req_pw;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [31:0] req_rs3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic        malu_valid;
    logic        malu_ready;
    logic        malu_flush;
    logic [31:0] malu_rs1;
    logic [31:0] malu_rs2;
    logic [31:0] malu_rs3;
    logic        malu_uop_div;
    logic        malu_uop_rem;
    logic        malu_uop_mul;
    logic        malu_uop_madd;
    logic        malu_uop_msub_1;
    logic        malu_uop_msub_2;
    logic        malu_uop_macc_1;
    logic        malu_uop_macc_2;
    logic        malu_mod_lh_sign;
    logic        malu_mod_rh_sign;
    logic        malu_mod_carryless;
    logic        malu_pw_32;
    logic        malu_pw_16;
    logic        malu_pw_8;
    logic        malu_pw_4;
    logic        malu_pw_2;
    logic [63:0] malu_result;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    xc_malu_seq dut (
        .clock              (clock),
        .resetn             (resetn),
        .abort              (abort),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_op             (req_op),
        .req_lh_sign        (req_lh_sign),
        .req_rh_sign        (req_rh_sign),
        .req_carryless      (req_carryless),
        .req_pw             (req_pw),
        .req_rs1            (req_rs1),
        .req_rs2            (req_rs2),
        .req_rs3            (req_rs3),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_result         (rsp_result),
        .malu_valid         (malu_valid),
        .malu_ready         (malu_ready),
        .malu_flush         (malu_flush),
        .malu_rs1           (malu_rs1),
        .malu_rs2           (malu_rs2),
        .malu_rs3           (malu_rs3),
        .malu_uop_div       (malu_uop_div),
        .malu_uop_rem       (malu_uop_rem),
        .malu_uop_mul       (malu_uop_mul),
        .malu_uop_madd      (malu_uop_madd),
        .malu_uop_msub_1    (malu_uop_msub_1),
        .malu_uop_msub_2    (malu_uop_msub_2),
        .malu_uop_macc_1    (malu_uop_macc_1),
        .malu_uop_macc_2    (malu_uop_macc_2),
        .malu_mod_lh_sign   (malu_mod_lh_sign),
        .malu_mod_rh_sign   (malu_mod_rh_sign),
        .malu_mod_carryless (malu_mod_carryless),
        .malu_pw_32         (malu_pw_32),
        .malu_pw_16         (malu_pw_16),
        .malu_pw_8          (malu_pw_8),
        .malu_pw_4          (malu_pw_4),
        .malu_pw_2          (malu_pw_2),
        .malu_result        (malu_result)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] pw,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c);
        req_valid = 1'b1;
        req_op    = op;
        req_pw    = pw;
        req_rs1   = a;
        req_rs2   = b;
        req_rs3   = c;
        #1;
        chk("req_ready_on_issue", req_ready, 1);
        tick();
        req_valid = 1'b0;
        #1;
    endtask

    task automatic malu_done(input logic [63:0] r);
        malu_ready  = 1'b1;
        malu_result = r;
        #1;
        chk("flush_on_done", malu_flush, 1);
        tick();
        malu_ready = 1'b0;
        #1;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("idle_after_rsp", req_ready, 1);
        chk("rsp_valid_drop", rsp_valid, 0);
    endtask

    initial begin
        int flushes;
        resetn = 0; abort = 0; req_valid = 0; req_op = 0;
        req_lh_sign = 0; req_rh_sign = 0; req_carryless = 0; req_pw = 0;
        req_rs1 = 0; req_rs2 = 0; req_rs3 = 0; rsp_ready = 0;
        malu_ready = 0; malu_result = 0;
        tick(); tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_malu_valid", malu_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        resetn = 1;
        #1;

        // MUL unsigned 0xFFFFFFFF * 2 with a 4-cycle xc_malu wait
        issue(4'd2, 3'd0, 32'hFFFF_FFFF, 32'h2, 32'h0);
        chk("mul_valid_t1", malu_valid, 1);
        chk("mul_uop", malu_uop_mul, 1);
        chk("mul_rs1", malu_rs1, 64'hFFFF_FFFF);
        chk("mul_rs2", malu_rs2, 2);
        chk("mul_pw32", malu_pw_32, 1);
        flushes = 0;
        for (int i = 0; i < 4; i++) begin
            if (malu_flush) flushes++;
            tick();
        end
        chk("mul_held_valid", malu_valid, 1);
        chk("mul_held_rs1", malu_rs1, 64'hFFFF_FFFF);
        chk("mul_no_early_flush", flushes, 0);
        malu_done(64'h0000_0001_FFFF_FFFE);
        chk("mul_rsp_valid", rsp_valid, 1);
        chk("mul_result", rsp_result, 64'h0000_0001_FFFF_FFFE);
        chk("mul_valid_drop", malu_valid, 0);
        chk("mul_flush_once", malu_flush, 0);
        consume();

        // MACC 3,5,9: phase-1 result feeds phase 2 through acc
        issue(4'd5, 3'd0, 32'd3, 32'd5, 32'd9);
        chk("macc_uop1", malu_uop_macc_1, 1);
        malu_done(64'h0000_0002_0000_000F);
        chk("macc2_valid", malu_valid, 1);
        chk("macc2_uop", malu_uop_macc_2, 1);
        chk("macc2_uop1_off", malu_uop_macc_1, 0);
        chk("macc2_rs1", malu_rs1, 32'h0000_000F);
        chk("macc2_rs2", malu_rs2, 32'h0000_0002);
        chk("macc2_rs3", malu_rs3, 9);
        chk("macc2_no_rsp", rsp_valid, 0);
        malu_done(64'h0000_0002_0000_0018);
        chk("macc_rsp_valid", rsp_valid, 1);
        chk("macc_result", rsp_result, 64'h0000_0002_0000_0018);
        consume();

        // DIV 7/0 with rsp_ready stalled for 5 cycles
        issue(4'd0, 3'd0, 32'd7, 32'd0, 32'd0);
        chk("div_uop", malu_uop_div, 1);
        malu_done(64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            chk("div_stall_valid", rsp_valid, 1);
            chk("div_stall_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("div_stall_req_ready", req_ready, 0);
            tick();
        end
        consume();

        // MSUB aborted in ISSUE2, same cycle as malu_ready
        issue(4'd4, 3'd0, 32'd4, 32'd6, 32'd1);
        chk("msub_uop1", malu_uop_msub_1, 1);
        malu_done(64'h0000_0000_0000_0018);
        chk("msub2_uop", malu_uop_msub_2, 1);
        malu_ready = 1; malu_result = 64'h1234; abort = 1;
        #1;
        chk("abort_flush", malu_flush, 1);
        chk("abort_req_ready", req_ready, 0);
        tick();
        malu_ready = 0; abort = 0;
        #1;
        chk("abort_no_rsp", rsp_valid, 0);
        chk("abort_no_valid", malu_valid, 0);
        chk("abort_idle", req_ready, 1);

        // illegal op: straight to RESP with 0, then dropped by abort
        issue(4'hF, 3'd0, 32'd1, 32'd1, 32'd1);
        chk("ill_no_valid", malu_valid, 0);
        chk("ill_rsp_valid", rsp_valid, 1);
        chk("ill_result", rsp_result, 0);
        abort = 1;
        tick();
        abort = 0;
        #1;
        chk("resp_abort_drop", rsp_valid, 0);
        chk("resp_abort_idle", req_ready, 1);

        // illegal pw with a legal op
        issue(4'd2, 3'd5, 32'd2, 32'd2, 32'd0);
        chk("illpw_no_valid", malu_valid, 0);
        chk("illpw_rsp", rsp_valid, 1);
        consume();

        // abort with req_valid in IDLE is not accepted
        req_valid = 1; req_op = 4'd2; abort = 1;
        #1;
        chk("abort_idle_ready", req_ready, 0);
        tick();
        req_valid = 0; abort = 0;
        #1;
        chk("abort_idle_no_issue", malu_valid, 0);

        // 1-cycle reset while in ISSUE1, then MUL 2*3
        issue(4'd2, 3'd1, 32'd9, 32'd9, 32'd9);
        chk("pre_rst_valid", malu_valid, 1);
        chk("pre_rst_pw16", malu_pw_16, 1);
        resetn = 0; malu_ready = 1;
        #1;
        chk("rst_mid_valid", malu_valid, 0);
        chk("rst_mid_flush", malu_flush, 0);
        chk("rst_mid_rs1", malu_rs1, 0);
        chk("rst_mid_uop", malu_uop_mul, 0);
        chk("rst_mid_pw", malu_pw_16, 0);
        chk("rst_mid_req_ready", req_ready, 0);
        tick();
        resetn = 1; malu_ready = 0;
        #1;
        chk("post_rst_idle", req_ready, 1);
        chk("post_rst_valid", malu_valid, 0);
        issue(4'd2, 3'd0, 32'd2, 32'd3, 32'd0);
        chk("mul23_rs1", malu_rs1, 2);
        chk("mul23_rs2", malu_rs2, 3);
        malu_done(64'd6);
        chk("mul23_result", rsp_result, 6);
        consume();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
